lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised N-bit LFSR, successor to the fixed 8-bit Fibonacci generator.
- Runtime-writable tap register and selectable Fibonacci or Galois mode.
- Parallel seed load and serial shift-in.
- Automatic all-zero lock-up recovery, plus a period detector that reports the step count to return to the seed.
- Sits in the pattern/PRBS path; feeds serial consumers via lfsr_out and parallel consumers via s_reg.

Parameters:
N, 8, state/tap width (N >= 3)
DEFAULT_TAPS, 8'hB8 (N bits), tap register value after reset
DEFAULT_SEED, 8'h01 (N bits, must be nonzero), state after reset and lock-up recovery

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  advance LFSR one step
mode  input  1  0 = Fibonacci, 1 = Galois; sampled on each step
load  input  1  parallel load of seed
seed  input  N  parallel seed value
load_ser  input  1  serial shift-in
s_reg_in  input  1  serial data bit
taps_we  input  1  write taps into tap register
taps  input  N  new tap value
s_reg  output  N  current state (registered)
lfsr_out  output  1  s_reg[N-1] (combinational from register)
period_done  output  1  one-cycle pulse when the state returns to seed_q
period_len  output  N  step count latched at the last period_done
lockup_err  output  1  sticky: all-zero state was recovered

Behaviour:
- Reset values (reset low, asynchronous):
  - s_reg = DEFAULT_SEED, taps_q = DEFAULT_TAPS, seed_q = DEFAULT_SEED.
  - step_cnt = 0, period_len = 0, period_done = 0, lockup_err = 0.
- Reset asserted mid-operation aborts immediately to these values.
- Next-state priority per cycle: load > load_ser > lock-up recovery > en > hold.
- load:
  - s_reg <= seed, seed_q <= seed, step_cnt <= 0, lockup_err <= 0.
  - A zero seed is accepted as-is.
- load_ser:
  - s_reg <= {s_reg[N-2:0], s_reg_in}, step_cnt <= 0.
  - seed_q is unchanged.
- Lock-up recovery:
  - Condition: en=1, no load or load_ser, and s_reg == 0.
  - s_reg <= DEFAULT_SEED, lockup_err <= 1, step_cnt <= 0; no step is counted.
- Fibonacci step (mode=0):
  - fb = ^(s_reg & taps_q); s_reg <= {s_reg[N-2:0], fb}.
  - taps_q bit i selects s_reg[i].
- Galois step (mode=1):
  - s_reg <= {s_reg[N-2:0],1'b0} ^ (s_reg[N-1] ? taps_q : 0).
  - taps_q bit i is the coefficient of x^i; x^N is implicit.
- Latency: one step per enabled cycle; s_reg and lfsr_out reflect the step on the following cycle.
- Period detection:
  - On each counted step, step_cnt increments, saturating at 2^N-1.
  - If the next state equals seed_q: period_done = 1 for exactly the cycle in which s_reg == seed_q, period_len <= step_cnt+1, step_cnt <= 0.
  - period_done = 0 in all other cycles, including load cycles.
- Tap writes:
  - taps_we: taps_q <= taps, effective from the next cycle's step.
  - Independent of load/en and never clears counters.
  - All-zero taps are legal; the state then drains to zero and is recovered by the lock-up rule.
- Mode change mid-run:
  - Takes effect on the next step; counters are not cleared.
  - period_len after a mode change is not guaranteed meaningful until the next load.
- en=0 and no load: all state holds; period_done = 0.

Decomposition:
- Package lfsr_pkg:
  - MODE_FIB = 1'b0, MODE_GAL = 1'b1.
  - Default maximal-length tap constants: FIB_TAPS_8 = 8'hB8, GAL_TAPS_8 = 8'h71.
- Sub-module lfsr_step_logic (combinational, parameter N):
  - Inputs: s_reg, taps_q, mode.
  - Outputs: next state and is_zero.
- lfsr_gen holds the registers, priority mux, counters and flags.

Test Plan:
- Fibonacci, N=8, taps 8'hB8, load seed 8'h01, en=1 -> s_reg 8'h02 after one step; period_done pulses after exactly 255 steps; period_len = 8'hFF.
- Galois, taps 8'h71, seed 8'h01, en=1 -> s_reg sequence 02,04,08,10,20,40,80,71; period_done after 255 steps with period_len = 8'hFF.
- Load 8'h00 then en=1 -> next cycle s_reg = 8'h01, lockup_err = 1 (sticky over 10 cycles); load 8'h05 -> lockup_err = 0.
- load=1 with en=1 and taps_we=1 (taps 8'h8E) in the same cycle -> s_reg = seed, step_cnt = 0; the next step uses 8'h8E.
- load_ser with s_reg_in bits 1,0,1 from s_reg 8'h01 -> s_reg 8'h0D; seed_q unchanged, so no period_done until the state revisits 8'h01.
- Reset pulsed low asynchronously mid-run (between clock edges) -> s_reg = 8'h01, period_len = 0, lockup_err = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared mode encodings and maximal-length tap constants for the LFSR
package lfsr_pkg;
  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;
  localparam logic [7:0] FIB_TAPS_8 = 8'hB8;
  localparam logic [7:0] GAL_TAPS_8 = 8'h71;
endpackage

// File: rtl/lfsr_step_logic.sv
// lfsr_step_logic: one combinational Fibonacci or Galois step plus all-zero detect
module lfsr_step_logic
  import lfsr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] s_reg,
  input  logic [N-1:0] taps_q,
  input  logic         mode,
  output logic [N-1:0] next_s,
  output logic         is_zero
);
  // Fibonacci feeds tap parity into bit 0; Galois folds taps in when the msb leaves
  always_comb begin
    next_s  = (mode == MODE_GAL) ? ({s_reg[N-2:0], 1'b0} ^ (s_reg[N-1] ? taps_q : '0))
                                 : {s_reg[N-2:0], ^(s_reg & taps_q)};
    is_zero = (s_reg == '0);
  end
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: N-bit LFSR with writable taps, seed/serial load, lock-up recovery and period detect
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int           N            = 8,
  parameter logic [N-1:0] DEFAULT_TAPS = 8'hB8,
  parameter logic [N-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         load_ser,
  input  logic         s_reg_in,
  input  logic         taps_we,
  input  logic [N-1:0] taps,
  output logic [N-1:0] s_reg,
  output logic         lfsr_out,
  output logic         period_done,
  output logic [N-1:0] period_len,
  output logic         lockup_err
);
  logic [N-1:0] s_reg_q, s_reg_d, seed_q, seed_d, taps_q, taps_d;
  logic [N-1:0] step_cnt_q, step_cnt_d, period_len_q, period_len_d, cnt_inc, next_s;
  logic         period_done_q, period_done_d, lockup_err_q, lockup_err_d, is_zero;

  lfsr_step_logic #(.N(N)) u_step (
    .s_reg  (s_reg_q),
    .taps_q (taps_q),
    .mode   (mode),
    .next_s (next_s),
    .is_zero(is_zero)
  );

  // priority mux: load > serial shift > lock-up recovery > step > hold
  always_comb begin
    s_reg_d       = s_reg_q;
    seed_d        = seed_q;
    taps_d        = taps_we ? taps : taps_q;
    step_cnt_d    = step_cnt_q;
    period_len_d  = period_len_q;
    period_done_d = 1'b0;
    lockup_err_d  = lockup_err_q;
    cnt_inc       = (step_cnt_q == '1) ? step_cnt_q : step_cnt_q + 1'b1;
    if (load) begin
      s_reg_d      = seed;
      seed_d       = seed;
      step_cnt_d   = '0;
      lockup_err_d = 1'b0;
    end else if (load_ser) begin
      s_reg_d    = {s_reg_q[N-2:0], s_reg_in};
      step_cnt_d = '0;
    end else if (en && is_zero) begin
      s_reg_d      = DEFAULT_SEED;
      lockup_err_d = 1'b1;
      step_cnt_d   = '0;
    end else if (en) begin
      s_reg_d       = next_s;
      period_done_d = (next_s == seed_q);
      period_len_d  = (next_s == seed_q) ? cnt_inc : period_len_q;
      step_cnt_d    = (next_s == seed_q) ? '0 : cnt_inc;
    end
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_reg_q       <= DEFAULT_SEED;
      seed_q        <= DEFAULT_SEED;
      taps_q        <= DEFAULT_TAPS;
      step_cnt_q    <= '0;
      period_len_q  <= '0;
      period_done_q <= 1'b0;
      lockup_err_q  <= 1'b0;
    end else begin
      s_reg_q       <= s_reg_d;
      seed_q        <= seed_d;
      taps_q        <= taps_d;
      step_cnt_q    <= step_cnt_d;
      period_len_q  <= period_len_d;
      period_done_q <= period_done_d;
      lockup_err_q  <= lockup_err_d;
    end
  end

  assign s_reg       = s_reg_q;
  assign lfsr_out    = s_reg_q[N-1];
  assign period_done = period_done_q;
  assign period_len  = period_len_q;
  assign lockup_err  = lockup_err_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed vector table plus hand sequences for period, lock-up and async reset
module tb_lfsr_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, mode = 1'b0, load = 1'b0, load_ser = 1'b0, s_reg_in = 1'b0, taps_we = 1'b0;
  logic [7:0] seed = 8'h00, taps = 8'h00;
  logic [7:0] s_reg, period_len;
  logic       lfsr_out, period_done, lockup_err;
  int         n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic       ld;
    logic [7:0] sd;
    logic       en;
    logic       md;
    logic       ls;
    logic       si;
    logic       tw;
    logic [7:0] tp;
    logic [7:0] es;
    logic       ed;
    logic       el;
  } vec_t;

  vec_t vt[28];

  lfsr_gen dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .seed(seed),
    .load_ser(load_ser), .s_reg_in(s_reg_in), .taps_we(taps_we), .taps(taps),
    .s_reg(s_reg), .lfsr_out(lfsr_out), .period_done(period_done),
    .period_len(period_len), .lockup_err(lockup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] sd, input logic e, input logic md,
                       input logic ls, input logic si, input logic tw, input logic [7:0] tp);
    load = ld; seed = sd; en = e; mode = md; load_ser = ls; s_reg_in = si; taps_we = tw; taps = tp;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_period(input string name, input logic [7:0] exp_s, output int n);
    n = 0;
    drive(0, 8'h00, 1, mode, 0, 0, 0, 8'h00);
    do begin
      tick();
      n++;
    end while (!period_done && n < 300);
    chk({name, "_done_seen"}, {7'd0, period_done}, 8'h01);
    chk({name, "_state"}, s_reg, exp_s);
    tick();
    chk({name, "_pulse_width"}, {7'd0, period_done}, 8'h00);
  endtask

  initial begin
    int n;
    vt[0]  = '{1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0};
    vt[1]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0};
    vt[2]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h04, 0, 0};
    vt[3]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h08, 0, 0};
    vt[4]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h11, 0, 0};
    vt[5]  = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h22, 0, 0};
    vt[6]  = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h22, 0, 0};
    vt[7]  = '{1, 8'h02, 1, 0, 0, 0, 1, 8'h8E, 8'h02, 0, 0};
    vt[8]  = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h05, 0, 0};
    vt[9]  = '{1, 8'h01, 0, 1, 0, 0, 1, 8'h71, 8'h01, 0, 0};
    vt[10] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h02, 0, 0};
    vt[11] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h04, 0, 0};
    vt[12] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h08, 0, 0};
    vt[13] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h10, 0, 0};
    vt[14] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h20, 0, 0};
    vt[15] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h40, 0, 0};
    vt[16] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h80, 0, 0};
    vt[17] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h71, 0, 0};
    vt[18] = '{1, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0};
    vt[19] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h01, 0, 1};
    vt[20] = '{0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h01, 0, 1};
    vt[21] = '{0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 8'h02, 0, 1};
    vt[22] = '{1, 8'h05, 0, 1, 0, 0, 0, 8'h00, 8'h05, 0, 0};
    vt[23] = '{1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0};
    vt[24] = '{0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h03, 0, 0};
    vt[25] = '{0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 8'h06, 0, 0};
    vt[26] = '{0, 8'h00, 0, 0, 1, 1, 0, 8'h00, 8'h0D, 0, 0};
    vt[27] = '{0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 8'h1A, 0, 0};

    #12;
    chk("reset_s_reg", s_reg, 8'h01);
    chk("reset_period_len", period_len, 8'h00);
    chk("reset_flags", {6'd0, period_done, lockup_err}, 8'h00);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 28; i++) begin
      drive(vt[i].ld, vt[i].sd, vt[i].en, vt[i].md, vt[i].ls, vt[i].si, vt[i].tw, vt[i].tp);
      tick();
      chk($sformatf("vec%0d_s_reg", i), s_reg, vt[i].es);
      chk($sformatf("vec%0d_lfsr_out", i), {7'd0, lfsr_out}, {7'd0, vt[i].es[7]});
      chk($sformatf("vec%0d_period_done", i), {7'd0, period_done}, {7'd0, vt[i].ed});
      chk($sformatf("vec%0d_lockup_err", i), {7'd0, lockup_err}, {7'd0, vt[i].el});
    end

    drive(1, 8'h01, 0, 0, 0, 0, 1, 8'hB8);
    tick();
    run_period("fib_period", 8'h01, n);
    chk("fib_steps", n[7:0], 8'hFF);
    chk("fib_period_len", period_len, 8'hFF);

    drive(1, 8'h01, 0, 1, 0, 0, 1, 8'h71);
    tick();
    run_period("gal_period", 8'h01, n);
    chk("gal_steps", n[7:0], 8'hFF);
    chk("gal_period_len", period_len, 8'hFF);

    drive(1, 8'h01, 0, 0, 0, 0, 1, 8'hB8);
    tick();
    drive(0, 8'h00, 0, 0, 1, 1, 0, 8'h00); tick();
    drive(0, 8'h00, 0, 0, 1, 0, 0, 8'h00); tick();
    drive(0, 8'h00, 0, 0, 1, 1, 0, 8'h00); tick();
    chk("ser_state", s_reg, 8'h0D);
    run_period("ser_revisit", 8'h01, n);
    chk("ser_steps_bounded", {7'd0, n < 255}, 8'h01);
    chk("ser_period_len", period_len, n[7:0]);

    drive(1, 8'h00, 0, 0, 0, 0, 0, 8'h00); tick();
    drive(0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("lock_sticky%0d", i), {7'd0, lockup_err}, 8'h01);
    end
    #2 reset = 1'b0;
    #1;
    chk("async_s_reg", s_reg, 8'h01);
    chk("async_period_len", period_len, 8'h00);
    chk("async_lockup", {7'd0, lockup_err}, 8'h00);
    drive(0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    #10 reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
